// File: rtl/qci_queue_dispatcher.sv
// Qci queue dispatcher: steers whole gated frames into one of eight priority-queue
// write ports, drops frames aimed at trash/illegal tags or at a full queue, and keeps
// per-queue forwarded and global dropped frame counters.
module qci_queue_dispatcher #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = 8,
  parameter int unsigned LEN_W  = 11,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_Q  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_axis_tdata,
  input  logic [KEEP_W-1:0] rx_axis_tkeep,
  input  logic              rx_axis_tlast,
  input  logic              rx_axis_tvalid,
  output logic              rx_axis_tready,
  input  logic [3:0]        rx_axis_tdest,
  input  logic [LEN_W-1:0]  frame_len_in,
  input  logic [NUM_Q-1:0]  isFull_queue,
  output logic [DATA_W-1:0] q_wr_data,
  output logic [KEEP_W-1:0] q_wr_keep,
  output logic              q_wr_last,
  output logic              q_wr_sof,
  output logic [LEN_W-1:0]  q_wr_len,
  output logic [NUM_Q-1:0]  q_wr_en,
  input  logic [2:0]        fwd_cnt_sel,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  input  logic              clr_stats
);

  localparam int unsigned QIDX_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [QIDX_W-1:0]   tgt_q, tgt_d;
  logic [DATA_W-1:0]   q_wr_data_q, q_wr_data_d;
  logic [KEEP_W-1:0]   q_wr_keep_q, q_wr_keep_d;
  logic                q_wr_last_q, q_wr_last_d;
  logic                q_wr_sof_q, q_wr_sof_d;
  logic [LEN_W-1:0]    q_wr_len_q, q_wr_len_d;
  logic [NUM_Q-1:0]    q_wr_en_q, q_wr_en_d;
  logic [CNT_W-1:0]    fwd_cnt_q [NUM_Q];
  logic [CNT_W-1:0]    fwd_cnt_d [NUM_Q];
  logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

  logic                rx_ready_c;
  logic                beat_c;
  logic                fwd_ok_c;
  logic                inc_fwd_c;
  logic                inc_drop_c;
  logic [QIDX_W-1:0]   inc_idx_c;

  // Ready: only a forwarding frame can be back-pressured, and only by its own queue.
  always_comb begin
    rx_ready_c = 1'b1;
    if (state_q == FWD) begin
      rx_ready_c = ~isFull_queue[tgt_q];
    end
  end

  assign beat_c   = rx_axis_tvalid & rx_ready_c;
  assign fwd_ok_c = ~rx_axis_tdest[3] & ~isFull_queue[rx_axis_tdest[QIDX_W-1:0]];

  // Next-state, write-port and counter-event logic.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    q_wr_data_d = q_wr_data_q;
    q_wr_keep_d = q_wr_keep_q;
    q_wr_last_d = q_wr_last_q;
    q_wr_sof_d  = 1'b0;
    q_wr_len_d  = q_wr_len_q;
    q_wr_en_d   = '0;
    inc_fwd_c   = 1'b0;
    inc_drop_c  = 1'b0;
    inc_idx_c   = tgt_q;

    if (beat_c) begin
      q_wr_data_d = rx_axis_tdata;
      q_wr_keep_d = rx_axis_tkeep;
      q_wr_last_d = rx_axis_tlast;
    end

    case (state_q)
      IDLE: begin
        if (beat_c) begin
          tgt_d     = rx_axis_tdest[QIDX_W-1:0];
          inc_idx_c = rx_axis_tdest[QIDX_W-1:0];
          if (fwd_ok_c) begin
            q_wr_en_d  = NUM_Q'(1) << rx_axis_tdest[QIDX_W-1:0];
            q_wr_sof_d = 1'b1;
            q_wr_len_d = frame_len_in;
            if (rx_axis_tlast) inc_fwd_c = 1'b1;
            else               state_d   = FWD;
          end else begin
            if (rx_axis_tlast) inc_drop_c = 1'b1;
            else               state_d    = DROP;
          end
        end
      end
      FWD: begin
        if (beat_c) begin
          q_wr_en_d = NUM_Q'(1) << tgt_q;
          if (rx_axis_tlast) begin
            inc_fwd_c = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DROP: begin
        if (beat_c && rx_axis_tlast) begin
          inc_drop_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics: clear wins over increment; increments saturate at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_Q; i++) begin
      fwd_cnt_d[i] = fwd_cnt_q[i];
      if (clr_stats) begin
        fwd_cnt_d[i] = '0;
      end else if (inc_fwd_c && (inc_idx_c == QIDX_W'(i)) && !(&fwd_cnt_q[i])) begin
        fwd_cnt_d[i] = fwd_cnt_q[i] + CNT_W'(1);
      end
    end
    drop_cnt_d = drop_cnt_q;
    if (clr_stats) begin
      drop_cnt_d = '0;
    end else if (inc_drop_c && !(&drop_cnt_q)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // State and write-port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      q_wr_data_q <= '0;
      q_wr_keep_q <= '0;
      q_wr_last_q <= 1'b0;
      q_wr_sof_q  <= 1'b0;
      q_wr_len_q  <= '0;
      q_wr_en_q   <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      q_wr_data_q <= q_wr_data_d;
      q_wr_keep_q <= q_wr_keep_d;
      q_wr_last_q <= q_wr_last_d;
      q_wr_sof_q  <= q_wr_sof_d;
      q_wr_len_q  <= q_wr_len_d;
      q_wr_en_q   <= q_wr_en_d;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_Q; i++) fwd_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_Q; i++) fwd_cnt_q[i] <= fwd_cnt_d[i];
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign rx_axis_tready = rx_ready_c;
  assign q_wr_data      = q_wr_data_q;
  assign q_wr_keep      = q_wr_keep_q;
  assign q_wr_last      = q_wr_last_q;
  assign q_wr_sof       = q_wr_sof_q;
  assign q_wr_len       = q_wr_len_q;
  assign q_wr_en        = q_wr_en_q;
  assign fwd_cnt        = fwd_cnt_q[fwd_cnt_sel];
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_qci_queue_dispatcher.sv
// Directed bench for qci_queue_dispatcher.
module tb_qci_queue_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] rx_axis_tdata;
  logic [7:0]  rx_axis_tkeep;
  logic        rx_axis_tlast;
  logic        rx_axis_tvalid;
  logic        rx_axis_tready;
  logic [3:0]  rx_axis_tdest;
  logic [10:0] frame_len_in;
  logic [7:0]  isFull_queue;
  logic [63:0] q_wr_data;
  logic [7:0]  q_wr_keep;
  logic        q_wr_last;
  logic        q_wr_sof;
  logic [10:0] q_wr_len;
  logic [7:0]  q_wr_en;
  logic [2:0]  fwd_cnt_sel;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic        clr_stats;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  qci_queue_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .rx_axis_tdata(rx_axis_tdata), .rx_axis_tkeep(rx_axis_tkeep),
    .rx_axis_tlast(rx_axis_tlast), .rx_axis_tvalid(rx_axis_tvalid),
    .rx_axis_tready(rx_axis_tready), .rx_axis_tdest(rx_axis_tdest),
    .frame_len_in(frame_len_in), .isFull_queue(isFull_queue),
    .q_wr_data(q_wr_data), .q_wr_keep(q_wr_keep), .q_wr_last(q_wr_last),
    .q_wr_sof(q_wr_sof), .q_wr_len(q_wr_len), .q_wr_en(q_wr_en),
    .fwd_cnt_sel(fwd_cnt_sel), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt),
    .clr_stats(clr_stats)
  );

  // Present one beat, let it be taken at the next edge, sample 1 ns later.
  task automatic beat(input logic [63:0] d, input logic last, input logic [3:0] dest,
                      input logic [10:0] len);
    rx_axis_tdata  = d;
    rx_axis_tkeep  = 8'hFF;
    rx_axis_tlast  = last;
    rx_axis_tdest  = dest;
    frame_len_in   = len;
    rx_axis_tvalid = 1'b1;
    @(posedge clk); #1;
    rx_axis_tvalid = 1'b0;
  endtask

  task automatic idle_cycle();
    rx_axis_tvalid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rx_axis_tready !== 1'b1) begin failures++; $display("FAIL reset_tready got=%0b exp=1", rx_axis_tready); end
    checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL reset_en got=%h exp=00", q_wr_en); end
    checks++; if ({q_wr_sof, q_wr_last, q_wr_len} !== 13'd0) begin failures++; $display("FAIL reset_sof_last_len got=%b/%b/%0d exp=0", q_wr_sof, q_wr_last, q_wr_len); end
    checks++; if (q_wr_data !== 64'd0 || q_wr_keep !== 8'd0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", q_wr_data, q_wr_keep); end
    checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    rst_n = 1'b1;
    idle_cycle();
  endtask

  // 3-beat frame to queue 5; a different tdest on beat 2 must be ignored.
  task automatic test_forward();
    do_clear();
    beat(64'hA000_0000_0000_0001, 1'b0, 4'd5, 11'd20);
    checks++; if (q_wr_en !== 8'h20) begin failures++; $display("FAIL fwd_b1_en got=%h exp=20", q_wr_en); end
    checks++; if (q_wr_sof !== 1'b1 || q_wr_len !== 11'd20) begin failures++; $display("FAIL fwd_b1_sof_len got=%b/%0d exp=1/20", q_wr_sof, q_wr_len); end
    checks++; if (q_wr_data !== 64'hA000_0000_0000_0001 || q_wr_last !== 1'b0) begin failures++; $display("FAIL fwd_b1_data got=%h/%b", q_wr_data, q_wr_last); end
    beat(64'hA000_0000_0000_0002, 1'b0, 4'd8, 11'd99);
    checks++; if (q_wr_en !== 8'h20 || q_wr_sof !== 1'b0) begin failures++; $display("FAIL fwd_b2 got en=%h sof=%b exp=20/0", q_wr_en, q_wr_sof); end
    beat(64'hA000_0000_0000_0003, 1'b1, 4'd1, 11'd5);
    checks++; if (q_wr_en !== 8'h20 || q_wr_last !== 1'b1 || q_wr_data !== 64'hA000_0000_0000_0003) begin failures++; $display("FAIL fwd_b3 got en=%h last=%b data=%h", q_wr_en, q_wr_last, q_wr_data); end
    idle_cycle();
    checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL fwd_idle_en got=%h exp=00", q_wr_en); end
    fwd_cnt_sel = 3'd5; #1;
    checks++; if (fwd_cnt !== 32'd1) begin failures++; $display("FAIL fwd_cnt5 got=%0d exp=1", fwd_cnt); end
    checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL fwd_drop got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_drop_tags();
    do_clear();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 2; b++) begin
        beat(64'h5500 + 64'(b), (b == 1), (f == 0) ? 4'd8 : 4'd12, 11'd16);
        checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL drop_tag_en f=%0d b=%0d got=%h exp=00", f, b, q_wr_en); end
        checks++; if (rx_axis_tready !== 1'b1) begin failures++; $display("FAIL drop_tag_ready f=%0d b=%0d got=%b exp=1", f, b, rx_axis_tready); end
      end
    end
    checks++; if (drop_cnt !== 32'd2) begin failures++; $display("FAIL drop_tag_cnt got=%0d exp=2", drop_cnt); end
  endtask

  // Queue 2 full at first beat; releasing it later must not revive the frame.
  task automatic test_drop_full();
    do_clear();
    isFull_queue = 8'h04;
    beat(64'h22, 1'b0, 4'd2, 11'd24);
    checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL dfull_b1 got=%h exp=00", q_wr_en); end
    isFull_queue = 8'h00;
    beat(64'h23, 1'b0, 4'd2, 11'd24);
    beat(64'h24, 1'b1, 4'd2, 11'd24);
    checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL dfull_b3 got=%h exp=00", q_wr_en); end
    checks++; if (drop_cnt !== 32'd1) begin failures++; $display("FAIL dfull_drop got=%0d exp=1", drop_cnt); end
    fwd_cnt_sel = 3'd2; #1;
    checks++; if (fwd_cnt !== 32'd0) begin failures++; $display("FAIL dfull_fwd2 got=%0d exp=0", fwd_cnt); end
  endtask

  // Mid-frame full on the target stalls; full on another queue is ignored.
  task automatic test_stall();
    do_clear();
    isFull_queue = 8'h40;
    beat(64'h31, 1'b0, 4'd3, 11'd32);
    checks++; if (q_wr_en !== 8'h08 || q_wr_sof !== 1'b1) begin failures++; $display("FAIL stall_b1 got en=%h sof=%b exp=08/1", q_wr_en, q_wr_sof); end
    beat(64'h32, 1'b0, 4'd3, 11'd32);
    checks++; if (q_wr_en !== 8'h08 || rx_axis_tready !== 1'b1) begin failures++; $display("FAIL stall_b2 got en=%h rdy=%b exp=08/1", q_wr_en, rx_axis_tready); end
    isFull_queue   = 8'h08;
    rx_axis_tdata  = 64'h33;
    rx_axis_tlast  = 1'b0;
    rx_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rx_axis_tready !== 1'b0) begin failures++; $display("FAIL stall_ready c=%0d got=%b exp=0", c, rx_axis_tready); end
      @(posedge clk); #1;
      checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL stall_en c=%0d got=%h exp=00", c, q_wr_en); end
    end
    isFull_queue = 8'h00;
    beat(64'h33, 1'b0, 4'd3, 11'd32);
    checks++; if (q_wr_en !== 8'h08 || q_wr_data !== 64'h33) begin failures++; $display("FAIL stall_b3 got en=%h data=%h exp=08/33", q_wr_en, q_wr_data); end
    beat(64'h34, 1'b1, 4'd3, 11'd32);
    checks++; if (q_wr_en !== 8'h08 || q_wr_data !== 64'h34 || q_wr_last !== 1'b1) begin failures++; $display("FAIL stall_b4 got en=%h data=%h last=%b", q_wr_en, q_wr_data, q_wr_last); end
    idle_cycle();
    fwd_cnt_sel = 3'd3; #1;
    checks++; if (fwd_cnt !== 32'd1) begin failures++; $display("FAIL stall_fwd3 got=%0d exp=1", fwd_cnt); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    beat(64'h40, 1'b1, 4'd0, 11'd8);
    checks++; if (q_wr_en !== 8'h01 || q_wr_sof !== 1'b1 || q_wr_last !== 1'b1) begin failures++; $display("FAIL b2b_single got en=%h sof=%b last=%b", q_wr_en, q_wr_sof, q_wr_last); end
    beat(64'h70, 1'b0, 4'd7, 11'd64);
    checks++; if (q_wr_en !== 8'h80 || q_wr_sof !== 1'b1 || q_wr_len !== 11'd64) begin failures++; $display("FAIL b2b_next got en=%h sof=%b len=%0d exp=80/1/64", q_wr_en, q_wr_sof, q_wr_len); end
    beat(64'h71, 1'b1, 4'd7, 11'd64);
    idle_cycle();
    fwd_cnt_sel = 3'd0; #1;
    checks++; if (fwd_cnt !== 32'd1) begin failures++; $display("FAIL b2b_fwd0 got=%0d exp=1", fwd_cnt); end
    fwd_cnt_sel = 3'd7; #1;
    checks++; if (fwd_cnt !== 32'd1) begin failures++; $display("FAIL b2b_fwd7 got=%0d exp=1", fwd_cnt); end
  endtask

  // clr_stats in the same cycle as a frame-ending beat wins.
  task automatic test_clear();
    clr_stats = 1'b1;
    beat(64'h90, 1'b1, 4'd9, 11'd8);
    clr_stats = 1'b0;
    checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL clr_drop got=%0d exp=0", drop_cnt); end
    fwd_cnt_sel = 3'd0; #1;
    checks++; if (fwd_cnt !== 32'd0) begin failures++; $display("FAIL clr_fwd0 got=%0d exp=0", fwd_cnt); end
  endtask

  task automatic test_reset_midframe();
    beat(64'hAA, 1'b1, 4'd9, 11'd8);
    beat(64'h4001, 1'b0, 4'd4, 11'd40);
    checks++; if (q_wr_en !== 8'h10) begin failures++; $display("FAIL rmid_b1 got=%h exp=10", q_wr_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q_wr_en !== 8'h00 || q_wr_sof !== 1'b0 || q_wr_data !== 64'd0) begin failures++; $display("FAIL rmid_outs got en=%h sof=%b data=%h exp=0", q_wr_en, q_wr_sof, q_wr_data); end
    checks++; if (rx_axis_tready !== 1'b1 || drop_cnt !== 32'd0) begin failures++; $display("FAIL rmid_rdy_drop got=%b/%0d exp=1/0", rx_axis_tready, drop_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    beat(64'h1001, 1'b0, 4'd1, 11'd12);
    checks++; if (q_wr_en !== 8'h02 || q_wr_sof !== 1'b1 || q_wr_len !== 11'd12) begin failures++; $display("FAIL rmid_new_b1 got en=%h sof=%b len=%0d exp=02/1/12", q_wr_en, q_wr_sof, q_wr_len); end
    idle_cycle();
    checks++; if (q_wr_en !== 8'h00) begin failures++; $display("FAIL rmid_bubble got=%h exp=00", q_wr_en); end
    beat(64'h1002, 1'b1, 4'd6, 11'd3);
    checks++; if (q_wr_en !== 8'h02 || q_wr_last !== 1'b1 || q_wr_sof !== 1'b0) begin failures++; $display("FAIL rmid_new_b2 got en=%h last=%b sof=%b", q_wr_en, q_wr_last, q_wr_sof); end
    idle_cycle();
    for (int i = 0; i < 8; i++) begin
      fwd_cnt_sel = 3'(i); #1;
      checks++; if (fwd_cnt !== ((i == 1) ? 32'd1 : 32'd0)) begin failures++; $display("FAIL rmid_fwd%0d got=%0d exp=%0d", i, fwd_cnt, (i == 1) ? 1 : 0); end
    end
    checks++; if (drop_cnt !== 32'd0) begin failures++; $display("FAIL rmid_drop got=%0d exp=0", drop_cnt); end
  endtask

  initial begin
    rx_axis_tdata  = '0;
    rx_axis_tkeep  = '0;
    rx_axis_tlast  = 1'b0;
    rx_axis_tvalid = 1'b0;
    rx_axis_tdest  = '0;
    frame_len_in   = '0;
    isFull_queue   = '0;
    fwd_cnt_sel    = '0;
    clr_stats      = 1'b0;
    test_reset();
    test_forward();
    test_drop_tags();
    test_drop_full();
    test_stall();
    test_back_to_back();
    test_clear();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
